// File: rtl/robo_pkg.sv
// ============================================================================
// Module   : robo_pkg
// Purpose  : Shared FSM state encoding and rotation direction constants for
//            the wall-following robot.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

package robo_pkg;

  localparam logic DIR_ESQ = 1'b0;
  localparam logic DIR_DIR = 1'b1;

  // TRAVADO only exists when stuck detection is compiled in
  typedef enum logic [2:0] {
    PROCURA = 3'd0,
    SEGUE   = 3'd1,
    GIRA    = 3'd2,
    CANTO   = 3'd3
`ifdef ROBO_STUCK_DETECT_EN
    ,
    TRAVADO = 3'd4
`endif
  } robo_state_t;

endpackage

`default_nettype wire

// File: rtl/robo_debounce.sv
// ============================================================================
// Module   : robo_debounce
// Purpose  : Single-bit sensor debounce; the output follows the input only
//            after DEB_CYCLES consecutive edges of disagreement.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module robo_debounce #(
  parameter int DEB_CYCLES = 3
) (
  input  logic clock,
  input  logic reset,
  input  logic sensor_in,
  output logic filt_out
);

  localparam int CW = (DEB_CYCLES > 1) ? $clog2(DEB_CYCLES) : 1;

  logic [CW-1:0] r_cnt;

  // Counter tracks how many edges the raw input has disagreed so far
  always_ff @(posedge clock) begin
    if (reset) begin
      r_cnt    <= '0;
      filt_out <= 1'b0;
    end else if (sensor_in != filt_out) begin
      if (r_cnt == CW'(DEB_CYCLES - 1)) begin
        filt_out <= sensor_in;
        r_cnt    <= '0;
      end else begin
        r_cnt <= r_cnt + 1'b1;
      end
    end else begin
      r_cnt <= '0;
    end
  end

endmodule

`default_nettype wire

// File: rtl/robo_seguidor_parede.sv
// ============================================================================
// Module   : robo_seguidor_parede
// Purpose  : Wall-following robot controller with debounced sensors.
//            Optional stuck detection: define ROBO_STUCK_DETECT_EN.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module robo_seguidor_parede
  import robo_pkg::*;
#(
  parameter int DEB_CYCLES = 3,
  parameter int TURN_MAX   = 8,
  parameter int WALL_SIDE  = 0,
  parameter int CNT_W      = 4
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             head,
  input  logic             left,
  input  logic             right,
  input  logic             enable,
  output logic             avancar,
  output logic             girar,
  output logic             girar_dir,
  output logic             travado,
  output logic [CNT_W-1:0] voltas
);

  localparam int   DW     = $clog2(TURN_MAX);
  localparam logic c_wall = (WALL_SIDE != 0) ? DIR_DIR : DIR_ESQ;

  logic          w_h_f;
  logic          w_l_f;
  logic          w_r_f;
  logic          w_s_f;
  logic          w_unused_side;
  logic          w_dwell_done;
  robo_state_t   r_state;
  robo_state_t   w_next;
  logic [DW-1:0] r_dwell;

  robo_debounce #(.DEB_CYCLES(DEB_CYCLES)) u_deb_head (
    .clock(clock), .reset(reset), .sensor_in(head),  .filt_out(w_h_f));
  robo_debounce #(.DEB_CYCLES(DEB_CYCLES)) u_deb_left (
    .clock(clock), .reset(reset), .sensor_in(left),  .filt_out(w_l_f));
  robo_debounce #(.DEB_CYCLES(DEB_CYCLES)) u_deb_right (
    .clock(clock), .reset(reset), .sensor_in(right), .filt_out(w_r_f));

  assign w_s_f         = (WALL_SIDE != 0) ? w_r_f : w_l_f;
  assign w_unused_side = (WALL_SIDE != 0) ? w_l_f : w_r_f;
  assign w_dwell_done  = (r_dwell == DW'(TURN_MAX - 1));

  always_comb begin
    w_next = r_state;
    case (r_state)
      PROCURA: begin
        if (w_h_f)      w_next = GIRA;
        else if (w_s_f) w_next = SEGUE;
      end
      SEGUE: begin
        if (w_h_f)       w_next = GIRA;
        else if (!w_s_f) w_next = CANTO;
      end
      GIRA: begin
        if (!w_h_f)            w_next = w_s_f ? SEGUE : PROCURA;
`ifdef ROBO_STUCK_DETECT_EN
        else if (w_dwell_done) w_next = TRAVADO;
`endif
      end
      CANTO: begin
        if (w_h_f)             w_next = GIRA;
        else if (w_s_f)        w_next = SEGUE;
        else if (w_dwell_done) w_next = PROCURA;
      end
`ifdef ROBO_STUCK_DETECT_EN
      TRAVADO: w_next = TRAVADO;
`endif
      default: w_next = PROCURA;
    endcase
  end

  // Outputs decode the next state so they line up with the state register
  always_ff @(posedge clock) begin
    if (reset) begin
      r_state   <= PROCURA;
      r_dwell   <= '0;
      voltas    <= '0;
      avancar   <= 1'b0;
      girar     <= 1'b0;
      girar_dir <= 1'b0;
    end else if (!enable) begin
      avancar <= 1'b0;
      girar   <= 1'b0;
    end else begin
      r_state <= w_next;
      if (w_next != r_state)  r_dwell <= '0;
      else if (!w_dwell_done) r_dwell <= r_dwell + 1'b1;
      if (w_next == GIRA && r_state != GIRA && voltas != '1)
        voltas <= voltas + 1'b1;
      avancar   <= (w_next == PROCURA) || (w_next == SEGUE);
      girar     <= (w_next == GIRA) || (w_next == CANTO);
      girar_dir <= (w_next == GIRA)  ? ~c_wall :
                   (w_next == CANTO) ?  c_wall : 1'b0;
    end
  end

`ifdef ROBO_STUCK_DETECT_EN
  always_ff @(posedge clock) begin
    if (reset)       travado <= 1'b0;
    else if (enable) travado <= (w_next == TRAVADO);
  end
`else
  assign travado = 1'b0;
`endif

endmodule

`default_nettype wire

// File: tb/tb_robo_seguidor_parede.sv
// ============================================================================
// Module   : tb_robo_seguidor_parede
// Purpose  : Directed self-checking bench for robo_seguidor_parede.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_robo_seguidor_parede;

  logic       clock;
  logic       reset;
  logic       head;
  logic       left;
  logic       right;
  logic       enable;
  logic       avancar;
  logic       girar;
  logic       girar_dir;
  logic       travado;
  logic [3:0] voltas;

  int n_pass  = 0;
  int n_total = 0;

  robo_seguidor_parede dut (
    .clock(clock), .reset(reset), .head(head), .left(left), .right(right),
    .enable(enable), .avancar(avancar), .girar(girar), .girar_dir(girar_dir),
    .travado(travado), .voltas(voltas)
  );

  initial begin
    clock = 1'b0;
    forever #5 clock = ~clock;
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_total++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
  endtask

  // Advance n rising edges, then settle 1 time unit past the last one
  task automatic step(input int n);
    repeat (n) @(posedge clock);
    #1;
  endtask

  initial begin
    int girar_cycles;
    reset = 1'b1; enable = 1'b1; head = 1'b0; left = 1'b0; right = 1'b0;
    step(3);
    chk("rst_avancar", avancar, 0);
    chk("rst_girar",   girar,   0);
    chk("rst_voltas",  voltas,  0);
    chk("rst_travado", travado, 0);

    reset = 1'b0;
    step(1);
    chk("start_avancar", avancar, 1);
    chk("start_girar",   girar,   0);

    // Short head pulse must be filtered out
    head = 1'b1;
    step(1); chk("glitch_e1", avancar, 1);
    step(1); chk("glitch_e2", avancar, 1);
    head = 1'b0;
    step(3);
    chk("glitch_after", avancar, 1);
    chk("glitch_voltas", voltas, 0);

    // Obstacle ahead with wall on the left
    head = 1'b1; left = 1'b1;
    step(3);
    chk("hf_edge3_avancar", avancar, 1);
    step(1);
    chk("gira_girar", girar, 1);
    chk("gira_dir",   girar_dir, 1);
    chk("gira_av",    avancar, 0);
    chk("gira_voltas", voltas, 1);
    head = 1'b0;
    step(3);
    chk("gira_hold", girar, 1);
    step(1);
    chk("segue_av",    avancar, 1);
    chk("segue_girar", girar, 0);

    // Lose the wall: corner search for TURN_MAX cycles
    left = 1'b0;
    step(3);
    chk("segue_hold", avancar, 1);
    step(1);
    chk("canto_girar", girar, 1);
    chk("canto_dir",   girar_dir, 0);
    girar_cycles = 1;
    for (int i = 0; i < 7; i++) begin
      step(1);
      if (girar) girar_cycles++;
    end
    chk("canto_len", girar_cycles, 8);
    step(1);
    chk("canto_exit_av", avancar, 1);
    chk("canto_exit_gi", girar, 0);

    // Disable freezes state while filters keep running
    enable = 1'b0; head = 1'b1;
    for (int i = 0; i < 5; i++) begin
      step(1);
      chk("dis_av", avancar, 0);
      chk("dis_gi", girar, 0);
      chk("dis_voltas", voltas, 1);
    end
    enable = 1'b1;
    step(1);
    chk("resume_girar", girar, 1);
    chk("resume_voltas", voltas, 2);
    head = 1'b0;
    step(4);
    chk("resume_procura", avancar, 1);

    // Repeated GIRA entries saturate voltas
    for (int i = 0; i < 18; i++) begin
      head = 1'b1;
      step(4);
      chk("sat_voltas", voltas, (3 + i > 15) ? 15 : 3 + i);
      head = 1'b0;
      step(4);
    end
    chk("sat_final", voltas, 15);
    chk("sat_av", avancar, 1);

`ifdef ROBO_STUCK_DETECT_EN
    head = 1'b1;
    step(4);
    chk("stk_gira", girar, 1);
    step(7);
    chk("stk_pre", travado, 0);
    chk("stk_pre_gi", girar, 1);
    step(1);
    chk("stk_travado", travado, 1);
    chk("stk_av", avancar, 0);
    chk("stk_gi", girar, 0);
    head = 1'b0;
    step(5);
    chk("stk_sticky", travado, 1);
    reset = 1'b1;
    step(1);
    chk("stk_rst", travado, 0);
    reset = 1'b0;
    step(1);
    chk("stk_rel_av", avancar, 1);
`endif

    // Reset in the middle of a turn aborts it
    head = 1'b1;
    step(4);
    chk("mid_girar", girar, 1);
`ifndef ROBO_STUCK_DETECT_EN
    step(12);
    chk("nolimit_girar", girar, 1);
    chk("nolimit_trav", travado, 0);
`endif
    reset = 1'b1;
    step(1);
    chk("mid_rst_gi", girar, 0);
    chk("mid_rst_av", avancar, 0);
    chk("mid_rst_voltas", voltas, 0);
    reset = 1'b0;
    step(1);
    chk("mid_rel_av", avancar, 1);
    head = 1'b0;
    step(2);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL timeout: got no-finish expected finish");
    $fatal(1, "timeout");
  end

endmodule

`default_nettype wire

// File: doc/robo_seguidor_parede.md
ROBO_SEGUIDOR_PAREDE -- requirements
Module: robo_seguidor_parede

Interface
REQ-001 Parameter DEB_CYCLES, default 3: consecutive cycles a raw sensor must hold a new value before its filtered copy changes (>=1).
REQ-002 Parameter TURN_MAX, default 8: cycle limit for the CANTO search and for stuck detection (>=2).
REQ-003 Parameter WALL_SIDE, default 0: wall followed (0 = left, 1 = right).
REQ-004 Parameter CNT_W, default 4: width of the turn counter.
REQ-005 clock  input  1  rising-edge clock.
REQ-006 reset  input  1  synchronous, active-high reset.
REQ-007 head  input  1  raw front obstacle sensor.
REQ-008 left / right  input  1 each  raw side wall sensors.
REQ-009 enable  input  1  run permission; 0 freezes the FSM and forces the motion outputs to 0.
REQ-010 avancar  output  1  drive forward.
REQ-011 girar  output  1  rotate in place.
REQ-012 girar_dir  output  1  rotation direction (0 = left, 1 = right); valid only while girar=1.
REQ-013 travado  output  1  stuck flag; sticky.
REQ-014 voltas  output  CNT_W  count of entries into GIRA.

Function
REQ-015 Each of head, left and right SHALL pass an independent debounce filter, producing h_f, l_f and r_f.
- The filtered value takes the raw value on the DEB_CYCLES-th consecutive edge at which the raw input differs from the current filtered value.
- Shorter pulses SHALL be ignored.
REQ-016 The side sensor s_f SHALL be l_f when WALL_SIDE=0 and r_f when WALL_SIDE=1; the unused filtered side sensor is ignored.
REQ-017 FSM states PROCURA, SEGUE, GIRA, CANTO and TRAVADO SHALL be evaluated on filtered values; h_f has priority over s_f.
REQ-018 PROCURA: avancar=1. h_f -> GIRA; else s_f -> SEGUE.
REQ-019 SEGUE: avancar=1. h_f -> GIRA; else !s_f -> CANTO.
REQ-020 GIRA: girar=1, girar_dir=!WALL_SIDE (turn away from the wall). !h_f & s_f -> SEGUE; !h_f & !s_f -> PROCURA.
REQ-021 CANTO: girar=1, girar_dir=WALL_SIDE. h_f -> GIRA; else s_f -> SEGUE; else after TURN_MAX consecutive cycles in CANTO -> PROCURA.
REQ-022 All outputs SHALL be registered and computed from the next state, so the state and its outputs change on the same edge, one edge after the filtered input changes.
REQ-023 While enable=0: state, counters and travado hold; avancar=0 and girar=0; the filters keep running.
REQ-024 voltas SHALL increment by 1 on each transition into GIRA and saturate at 2^CNT_W-1.
REQ-025 Each dwell counter SHALL clear on state entry.

Reset
REQ-026 While reset=1, on each edge:
- state SHALL be PROCURA;
- filters, dwell counter, voltas, avancar, girar, girar_dir and travado SHALL be 0.
REQ-027 Asserting reset mid-turn or in TRAVADO SHALL abort immediately; the first edge after release with enable=1 SHALL give avancar=1.

Configuration
REQ-028 With ROBO_STUCK_DETECT_EN defined:
- TURN_MAX consecutive cycles in GIRA SHALL cause a transition to TRAVADO;
- TRAVADO SHALL give travado=1, avancar=0 and girar=0;
- TRAVADO SHALL be left only by reset.
REQ-029 Without ROBO_STUCK_DETECT_EN:
- TRAVADO SHALL be absent;
- travado SHALL be tied to 0;
- GIRA SHALL have no time limit.

Structure
REQ-030 Package robo_pkg SHALL hold the state enum and the direction constants DIR_ESQ=0 and DIR_DIR=1.
REQ-031 The debounce filter SHALL be sub-module robo_debounce (parameter DEB_CYCLES), instantiated three times.

Verification
All scenarios use the default parameters unless stated otherwise.
REQ-032 Release reset with enable=1 and all sensors 0 -> avancar=1, girar=0 on the first edge.
REQ-033 head=1 for 2 cycles -> h_f stays 0 and avancar stays 1.
REQ-034 head=1 and left=1 held -> h_f=1 at edge 3 and girar=1, girar_dir=1, voltas=1 at edge 4; head=0 then gives avancar=1 (SEGUE) 4 edges later.
REQ-035 In SEGUE, left drops to 0 and stays low -> CANTO with girar_dir=0 for 8 cycles, then PROCURA with avancar=1.
REQ-036 With ROBO_STUCK_DETECT_EN, head held high -> travado=1 after 8 cycles in GIRA; it stays 1 after head=0 until reset clears it.
REQ-037 20 GIRA entries -> voltas saturates at 15; enable=0 for 5 cycles -> state and voltas frozen, avancar=0, girar=0.
